// File: rtl/siso_frame_rx_pkg.sv
// Shared types, line levels and parity helper for the serial frame receiver.
package siso_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Parity bit a transmitter would append to word (zero-extended input).
  function automatic logic calc_parity(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/siso_frame_rx_if.sv
// Parallel word output with valid/ack handshake plus status flags.
interface siso_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ack;
  logic              busy;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output dout, dout_valid, busy, parity_err, frame_err, overrun,
    input  dout_ack
  );

  modport slave (
    input  dout, dout_valid, busy, parity_err, frame_err, overrun,
    output dout_ack
  );
endinterface

// File: rtl/siso_frame_rx.sv
// Deframes a start/data/parity/stop serial stream into parallel words.
module siso_frame_rx
  import siso_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            si,
  siso_frame_rx_if.master rx
);

  localparam int CW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_q;
  logic              last_bit;
  logic              stop_ok;
  logic              par_ok;
  logic              good;

  assign last_bit = (cnt_q == CW'(DATA_W - 1));
  assign stop_ok  = (si == STOP_BIT);
  assign par_ok   = (PARITY_EN == 0) ||
                    (calc_parity(32'(sh_q), (PARITY_ODD != 0)) == par_q);
  assign good     = (state_q == STOP) && stop_ok && par_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (si == START_BIT) state_d = DATA;
      DATA:    if (last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      par_q         <= 1'b0;
      rx.dout       <= '0;
      rx.dout_valid <= 1'b0;
      rx.busy       <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == DATA) ? cnt_q + CW'(1) : '0;

      // Clear on the start bit so a stale word never leaks into the next one.
      if (state_q == IDLE && si == START_BIT) sh_q <= '0;
      if (state_q == DATA) begin
        for (int i = 0; i < DATA_W; i++)
          if (cnt_q == CW'(i)) sh_q[i] <= si;
      end
      if (state_q == PARITY) par_q <= si;

      // busy tracks the state register, so it is high exactly in DATA..STOP.
      rx.busy       <= (state_d != IDLE);
      rx.frame_err  <= (state_q == STOP) && !stop_ok;
      rx.parity_err <= (state_q == STOP) && !par_ok;
      rx.overrun    <= good && rx.dout_valid && !rx.dout_ack;

      if (good) begin
        rx.dout       <= sh_q;
        rx.dout_valid <= 1'b1;
      end else if (rx.dout_ack && rx.dout_valid) begin
        rx.dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_siso_frame_rx.sv
// Directed frames with a scoreboard popped at every end of frame.
module tb_siso_frame_rx;

  logic clk = 1'b0;
  logic reset;
  logic si;

  siso_frame_rx_if #(.DATA_W(8)) rx ();

  siso_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk   (clk),
    .reset (reset),
    .si    (si),
    .rx    (rx.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic       vld;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] m_dout = '0;
  logic       m_vld  = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", n, act, exp, $time);
    end
  endtask

  // Frame ends (and reset aborts) show up as busy falling.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_prev && !rx.busy) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_end_unexpected @%0t", $time);
      end else begin
        e = q.pop_front();
        chk("dout",       rx.dout,       e.dout);
        chk("dout_valid", rx.dout_valid, e.vld);
        chk("parity_err", rx.parity_err, e.perr);
        chk("frame_err",  rx.frame_err,  e.ferr);
        chk("overrun",    rx.overrun,    e.ovr);
      end
    end else if (reset) begin
      chk("pulses_quiet", {rx.parity_err, rx.frame_err, rx.overrun}, 3'b000);
    end
    busy_prev = rx.busy;
  end

  task automatic send(input logic b, input logic a);
    @(negedge clk);
    si          = b;
    rx.dout_ack = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic stp, input logic ack_stop);
    exp_t e;
    send(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(d[i], 1'b0);
      if (i == 0) chk("busy_after_start", rx.busy, 1'b1);
    end
    send(p, 1'b0);
    send(stp, ack_stop);
    e.perr = (p != (^d));
    e.ferr = stp;
    if (!e.perr && !e.ferr) begin
      e.ovr  = m_vld && !ack_stop;
      m_dout = d;
      m_vld  = 1'b1;
    end else begin
      e.ovr = 1'b0;
      if (ack_stop && m_vld) m_vld = 1'b0;
    end
    e.dout = m_dout;
    e.vld  = m_vld;
    q.push_back(e);
  endtask

  task automatic ack_pulse;
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    m_vld = 1'b0;
    chk("ack_valid", rx.dout_valid, m_vld);
    chk("ack_dout",  rx.dout,       m_dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset       = 1'b0;
    si          = 1'b0;
    rx.dout_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout",  rx.dout,       8'h00);
    chk("rst_valid", rx.dout_valid, 1'b0);
    chk("rst_busy",  rx.busy,       1'b0);
    chk("rst_pulses", {rx.parity_err, rx.frame_err, rx.overrun}, 3'b000);
    reset = 1'b1;
    idle(2);

    // 0xA5: four ones, even parity bit 0
    frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(2);
    // 0x01 needs parity 1; sending 0 is a parity error
    frame(8'h01, 1'b0, 1'b0, 1'b0);
    idle(2);
    // 0x3C good parity, stop bit 1
    frame(8'h3C, 1'b0, 1'b1, 1'b0);
    idle(1);
    ack_pulse();
    // ack while nothing is valid is ignored
    ack_pulse();
    // 0x11 then back-to-back 0x22 without ack -> overrun
    frame(8'h11, 1'b0, 1'b0, 1'b0);
    frame(8'h22, 1'b0, 1'b0, 1'b0);
    idle(1);
    // ack colliding with completion of 0x7E: no overrun, stays valid
    frame(8'h7E, 1'b0, 1'b0, 1'b1);
    idle(1);
    ack_pulse();

    // reset after 4 data bits of 0xFF
    send(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    si    = 1'b0;
    e.dout = 8'h00; e.vld = 1'b0; e.perr = 1'b0; e.ferr = 1'b0; e.ovr = 1'b0;
    q.push_back(e);
    m_dout = 8'h00;
    m_vld  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    frame(8'h5A, 1'b0, 1'b0, 1'b0);
    idle(3);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siso_frame_rx.md
Name: siso_frame_rx

Overview:
- Downstream consumer of the single-bit serial shift stage: samples its serial output once per clock and deframes it.
- Frame format: start bit, DATA_W data bits (LSB first), optional even/odd parity bit, stop bit.
- Presents each good word on a parallel bus with a valid/ack handshake.
- Flags parity, stop-bit and overrun conditions.
- Line idles low: start bit = 1, stop bit = 0.

Parameters:
DATA_W, 8, data bits per frame (2..32)
PARITY_EN, 1, 1 = parity bit present between last data bit and stop bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
si  in  1  serial line from upstream shift stage, sampled every rising edge
dout  out  DATA_W  last good received word
dout_valid  out  1  level; high while dout holds an unacknowledged word
dout_ack  in  1  consumer acknowledge, sampled on rising edge
busy  out  1  high whenever FSM is not IDLE
parity_err  out  1  one-cycle pulse on parity mismatch
frame_err  out  1  one-cycle pulse on stop bit = 1
overrun  out  1  one-cycle pulse when a good word overwrites an unacked word

Behaviour:
- Reset (clock edge with reset=0):
  - state=IDLE, shift register=0, bit counter=0.
  - dout=0, dout_valid=0, busy=0, all error pulses=0.
  - Reset dominates dout_ack and si; reset mid-frame aborts the frame with no flags.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: si=1 on an edge -> DATA, counter=0. si=0 -> stay.
  - DATA: shift si into bit [counter] (LSB first) and increment counter. After the DATA_W-th data edge -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture si as received parity -> STOP.
  - STOP: sample si, then always -> IDLE.
- STOP-edge outcome:
  - Frame good when stop bit=0 and, if PARITY_EN, (XOR of data bits ^ rx parity) == PARITY_ODD.
  - Good frame: dout<=shifted word, dout_valid<=1.
  - Stop bit=1: frame_err pulse. Parity mismatch: parity_err pulse. Both may pulse on the same edge.
  - Bad frame: dout and dout_valid unchanged.
- Latency: the start bit is sampled on edge 0. dout/dout_valid update on edge DATA_W+PARITY_EN+1 (edge 10 for the defaults) and are visible right after it.
- No resync after an error. The FSM returns to IDLE, and the next sampled 1 starts a new frame.
- Back-to-back frames: a start bit on the edge immediately after STOP is accepted (zero idle gap).
- Handshake:
  - dout_ack=1 with dout_valid=1 clears dout_valid on that edge.
  - dout_ack with dout_valid=0 is ignored.
  - Good frame completes on the same edge as an ack: dout takes the new word, dout_valid stays 1, no overrun.
  - Good frame completes with dout_valid=1 and no ack: dout overwritten, dout_valid stays 1, overrun pulse.
- busy=1 in DATA, PARITY and STOP; 0 in IDLE. Registered, so it rises the edge after the start bit is sampled.
- All outputs are registered; there are no combinational paths from si or dout_ack.
- Counter width: $clog2(DATA_W+1). Counter is held at 0 in IDLE.

Decomposition:
- Package siso_rx_pkg:
  - state enum (IDLE, DATA, PARITY, STOP)
  - constants START_BIT=1'b1, STOP_BIT=1'b0, IDLE_LEVEL=1'b0
  - parity function calc_parity(word, odd)
- No sub-module. Shift register, counter, FSM and handshake live in one file; the block is small enough that splitting adds only port plumbing.

Test Plan:
- Good frame, defaults. Assert reset=0 for 1 cycle, then drive 0xA5 as serial bits 1,1,0,1,0,0,1,0,1,0,0 (start, data LSB-first, even parity 0, stop) -> dout=0xA5 and dout_valid=1 after edge 10; busy high for edges 1..10; no error pulses.
- Parity error. Drive start, data 0x01, parity 0, stop 0 -> parity_err pulse 1 cycle; dout stays 0xA5 (or 0 after reset); dout_valid unchanged.
- Stop error. Drive 0x3C with correct parity and stop bit=1 -> frame_err pulse 1 cycle; no dout update; FSM in IDLE next cycle.
- Overrun and ack. Receive 0x11, no ack, then back-to-back 0x22 -> overrun pulse on the 0x22 STOP edge, dout=0x22, dout_valid=1. Then dout_ack=1 for 1 cycle -> dout_valid=0.
- Ack collides with completion. Hold dout_ack=1 on the STOP edge of 0x7E while 0x22 is still valid -> dout=0x7E, dout_valid=1, overrun=0.
- Reset mid-frame. Drop reset after 4 data bits of 0xFF -> next edge all outputs 0, state IDLE. A following good 0x5A frame is received correctly.
